// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch path and the load/store path.
// Round-robin on conflict, one outstanding access, and a bounded wait that turns a lost response into an error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    state_t     state;
    port_t      owner;
    port_t      last_gnt;
    port_t      sel;
    logic [7:0] cnt;
    logic       any_req;
    logic       accept;
    logic       in_wait;
    logic       resp_fire;

    // On conflict the requester that did not win last time gets the memory.
    always_comb begin
        sel = PORT_I;
        if (i_req && d_req) begin
            sel = (last_gnt == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            sel = PORT_D;
        end
    end

    assign any_req = reset && (state == IDLE) && (i_req || d_req);
    assign accept  = any_req && mem_ready;
    assign i_gnt   = accept && (sel == PORT_I);
    assign d_gnt   = accept && (sel == PORT_D);

    always_comb begin
        mem_valid = any_req;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_req) begin
            if (sel == PORT_D) begin
                mem_we    = d_we;
                mem_be    = d_be;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_be   = '1;
                mem_addr = i_addr;
            end
        end
    end

    // A real response beats the timeout when both land in the same cycle.
    assign in_wait   = reset && (state == WAIT);
    assign resp_fire = in_wait && (mem_rvalid || (cnt == CNT_LAST));

    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = '0;
        i_err    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        d_err    = 1'b0;
        if (resp_fire) begin
            if (owner == PORT_D) begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rvalid ? mem_rdata : '0;
                d_err    = !mem_rvalid;
            end else begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rvalid ? mem_rdata : '0;
                i_err    = !mem_rvalid;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= PORT_I;
            last_gnt <= PORT_D;
            cnt      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= sel;
                        last_gnt <= sel;
                        cnt      <= '0;
                        state    <= WAIT;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BE_W    = DATA_W / 8;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_gnt, i_rvalid, i_err;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [BE_W-1:0]   d_be = '0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_rvalid, d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_valid, mem_we;
    logic              mem_ready = 1'b0;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              busy;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    typedef struct {
        logic              rst_n;
        logic              ireq;
        logic [ADDR_W-1:0] iaddr;
        logic              dreq;
        logic              dwe;
        logic [BE_W-1:0]   dbe;
        logic [ADDR_W-1:0] daddr;
        logic [DATA_W-1:0] dwdata;
        logic              ready;
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
    } stim_t;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            if (failures <= 50)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s.rst_n = 1'b1; s.ireq = 1'b0; s.iaddr = '0; s.dreq = 1'b0; s.dwe = 1'b0; s.dbe = '0;
        s.daddr = '0; s.dwdata = '0; s.ready = 1'b0; s.rvalid = 1'b0; s.rdata = '0;
        return s;
    endfunction

    // Inputs change just after the rising edge; directed checks read outputs just after the falling edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        reset = s.rst_n; i_req = s.ireq; i_addr = s.iaddr;
        d_req = s.dreq; d_we = s.dwe; d_be = s.dbe; d_addr = s.daddr; d_wdata = s.dwdata;
        mem_ready = s.ready; mem_rvalid = s.rvalid; mem_rdata = s.rdata;
        @(negedge clk);
        #1;
    endtask

    // Transaction-level model: one pending access, its owner, and the cycle it was granted.
    int                cyc = 0;
    logic              m_pending = 1'b0;
    logic              m_owner_d = 1'b0;
    logic              m_last_d = 1'b1;
    int                m_grant_cyc = 0;
    logic              e_ig, e_ir, e_ie, e_dg, e_dr, e_de, e_mv, e_mwe, e_busy, win_d;
    logic [DATA_W-1:0] e_ird, e_drd, e_mwd, resp_data;
    logic [BE_W-1:0]   e_mbe;
    logic [ADDR_W-1:0] e_ma;

    always @(negedge clk) begin
        cyc++;
        {e_ig, e_ir, e_ie, e_dg, e_dr, e_de, e_mv, e_mwe, e_busy} = '0;
        e_ird = '0; e_drd = '0; e_mwd = '0; e_mbe = '0; e_ma = '0;
        if (!reset) begin
            m_pending = 1'b0;
            m_last_d  = 1'b1;
        end else if (m_pending) begin
            e_busy = 1'b1;
            if (mem_rvalid || (cyc - m_grant_cyc == TIMEOUT)) begin
                resp_data = mem_rvalid ? mem_rdata : '0;
                if (m_owner_d) begin
                    e_dr = 1'b1; e_drd = resp_data; e_de = !mem_rvalid;
                end else begin
                    e_ir = 1'b1; e_ird = resp_data; e_ie = !mem_rvalid;
                end
                m_pending = 1'b0;
            end
        end else if (i_req || d_req) begin
            win_d = (i_req && d_req) ? !m_last_d : d_req;
            e_mv  = 1'b1;
            if (win_d) begin
                e_mwe = d_we; e_mbe = d_be; e_ma = d_addr; e_mwd = d_wdata;
            end else begin
                e_mbe = {BE_W{1'b1}}; e_ma = i_addr;
            end
            if (mem_ready) begin
                e_ig = !win_d; e_dg = win_d;
                m_pending   = 1'b1;
                m_owner_d   = win_d;
                m_last_d    = win_d;
                m_grant_cyc = cyc;
            end
        end
        checkOutput("i_gnt", 64'(i_gnt), 64'(e_ig));
        checkOutput("i_rvalid", 64'(i_rvalid), 64'(e_ir));
        checkOutput("i_rdata", 64'(i_rdata), 64'(e_ird));
        checkOutput("i_err", 64'(i_err), 64'(e_ie));
        checkOutput("d_gnt", 64'(d_gnt), 64'(e_dg));
        checkOutput("d_rvalid", 64'(d_rvalid), 64'(e_dr));
        checkOutput("d_rdata", 64'(d_rdata), 64'(e_drd));
        checkOutput("d_err", 64'(d_err), 64'(e_de));
        checkOutput("mem_valid", 64'(mem_valid), 64'(e_mv));
        checkOutput("mem_we", 64'(mem_we), 64'(e_mwe));
        checkOutput("mem_be", 64'(mem_be), 64'(e_mbe));
        checkOutput("mem_addr", 64'(mem_addr), 64'(e_ma));
        checkOutput("mem_wdata", 64'(mem_wdata), 64'(e_mwd));
        checkOutput("busy", 64'(busy), 64'(e_busy));
    end

    initial begin
        stim_t s;
        int    pct;
        logic  exp_d;

        $display("[TB] reset with every input active");
        s = quiet(); s.rst_n = 1'b0; s.ireq = 1'b1; s.dreq = 1'b1; s.ready = 1'b1; s.rvalid = 1'b1;
        s.rdata = 32'hFFFF_FFFF;
        applyStimulus(s);
        checkOutput("rst_mem_valid", 64'(mem_valid), 64'd0);
        checkOutput("rst_gnts", 64'({i_gnt, d_gnt}), 64'd0);
        checkOutput("rst_rvalids", 64'({i_rvalid, d_rvalid, i_err, d_err}), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        applyStimulus(quiet());

        $display("[TB] single fetch with one-cycle memory");
        s = quiet(); s.ireq = 1'b1; s.iaddr = 32'h0000_0004; s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("t1_i_gnt", 64'(i_gnt), 64'd1);
        checkOutput("t1_mem_addr", 64'(mem_addr), 64'h4);
        checkOutput("t1_mem_be", 64'(mem_be), 64'hF);
        checkOutput("t1_busy_T", 64'(busy), 64'd0);
        s = quiet(); s.rvalid = 1'b1; s.rdata = 32'h0660_0093;
        applyStimulus(s);
        checkOutput("t1_i_rvalid", 64'(i_rvalid), 64'd1);
        checkOutput("t1_i_rdata", 64'(i_rdata), 64'h0660_0093);
        checkOutput("t1_i_err", 64'(i_err), 64'd0);
        checkOutput("t1_busy_T1", 64'(busy), 64'd1);
        applyStimulus(quiet());
        checkOutput("t1_busy_T2", 64'(busy), 64'd0);

        $display("[TB] round-robin between competing requesters");
        s = quiet(); s.rst_n = 1'b0;
        applyStimulus(s);
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2) == 1;
            s = quiet(); s.ireq = 1'b1; s.iaddr = 32'h0000_0008; s.dreq = 1'b1; s.dwe = 1'b1;
            s.dbe = 4'h3; s.daddr = 32'h0000_0100; s.dwdata = 32'hDEAD_BEEF; s.ready = 1'b1;
            applyStimulus(s);
            checkOutput("t2_i_gnt", 64'(i_gnt), 64'(!exp_d));
            checkOutput("t2_d_gnt", 64'(d_gnt), 64'(exp_d));
            if (exp_d) begin
                checkOutput("t2_mem_we", 64'(mem_we), 64'd1);
                checkOutput("t2_mem_be", 64'(mem_be), 64'h3);
                checkOutput("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
            end
            s.rvalid = 1'b1; s.rdata = 32'(k);
            applyStimulus(s);
            checkOutput("t2_d_rvalid", 64'(d_rvalid), 64'(exp_d));
            checkOutput("t2_i_rvalid", 64'(i_rvalid), 64'(!exp_d));
        end

        $display("[TB] memory not ready stalls the grant");
        for (int c = 0; c < 3; c++) begin
            s = quiet(); s.dreq = 1'b1; s.daddr = 32'h0000_0200;
            applyStimulus(s);
            checkOutput("t3_d_gnt_stall", 64'(d_gnt), 64'd0);
            checkOutput("t3_busy_stall", 64'(busy), 64'd0);
        end
        s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("t3_d_gnt", 64'(d_gnt), 64'd1);
        s = quiet(); s.rvalid = 1'b1; s.rdata = 32'h0000_00AA;
        applyStimulus(s);
        checkOutput("t3_d_rdata", 64'(d_rdata), 64'hAA);

        $display("[TB] fetch timeout then late response");
        s = quiet(); s.ireq = 1'b1; s.iaddr = 32'h0000_0040; s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("t4_i_gnt", 64'(i_gnt), 64'd1);
        for (int c = 1; c < TIMEOUT; c++) begin
            applyStimulus(quiet());
            checkOutput("t4_no_rvalid", 64'(i_rvalid), 64'd0);
            checkOutput("t4_busy", 64'(busy), 64'd1);
        end
        applyStimulus(quiet());
        checkOutput("t4_i_rvalid", 64'(i_rvalid), 64'd1);
        checkOutput("t4_i_err", 64'(i_err), 64'd1);
        checkOutput("t4_i_rdata", 64'(i_rdata), 64'd0);
        applyStimulus(quiet());
        s = quiet(); s.rvalid = 1'b1; s.rdata = 32'h1234_5678;
        applyStimulus(s);
        checkOutput("t4_late_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);

        $display("[TB] response on the timeout cycle");
        s = quiet(); s.dreq = 1'b1; s.daddr = 32'h0000_0300; s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("t5_d_gnt", 64'(d_gnt), 64'd1);
        for (int c = 1; c < TIMEOUT; c++) applyStimulus(quiet());
        s = quiet(); s.rvalid = 1'b1; s.rdata = 32'hCAFE_F00D;
        applyStimulus(s);
        checkOutput("t5_d_rvalid", 64'(d_rvalid), 64'd1);
        checkOutput("t5_d_err", 64'(d_err), 64'd0);
        checkOutput("t5_d_rdata", 64'(d_rdata), 64'hCAFE_F00D);

        $display("[TB] reset during an outstanding access");
        s = quiet(); s.ireq = 1'b1; s.dreq = 1'b1; s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("t6_i_gnt_before", 64'(i_gnt), 64'd1);
        applyStimulus(quiet());
        s = quiet(); s.rst_n = 1'b0;
        applyStimulus(s);
        checkOutput("t6_busy_in_reset", 64'(busy), 64'd0);
        s = quiet(); s.rvalid = 1'b1; s.rdata = 32'h5555_AAAA;
        applyStimulus(s);
        checkOutput("t6_no_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        checkOutput("t6_busy_after", 64'(busy), 64'd0);
        s = quiet(); s.ireq = 1'b1; s.dreq = 1'b1; s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("t6_i_gnt_after", 64'(i_gnt), 64'd1);
        checkOutput("t6_d_gnt_after", 64'(d_gnt), 64'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            case ((n / 500) % 3)
                0: pct = 40;
                1: pct = 6;
                default: pct = 0;
            endcase
            s.rst_n  = ($urandom_range(0, 199) != 0);
            s.ireq   = ($urandom_range(0, 99) < 55);
            s.iaddr  = $urandom;
            s.dreq   = ($urandom_range(0, 99) < 55);
            s.dwe    = 1'($urandom);
            s.dbe    = 4'($urandom);
            s.daddr  = $urandom;
            s.dwdata = $urandom;
            s.ready  = ($urandom_range(0, 99) < 70);
            s.rvalid = ($urandom_range(0, 99) < pct);
            s.rdata  = $urandom;
            applyStimulus(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
